// File: rtl/if_id_buffer_pkg.sv
// Shared constants and the entry layout for the fetch/decode instruction buffer.
package if_id_buffer_pkg;

   localparam int IW_DEF = 16;

   localparam logic [IW_DEF-1:0] NOP_INSTR  = 16'h0800;
   localparam logic [IW_DEF-1:0] HALT_INSTR = 16'h0000;

   typedef struct packed {
      logic [IW_DEF-1:0] instr;
      logic [IW_DEF-1:0] pc2;
   } entry_t;

endpackage : if_id_buffer_pkg

// File: rtl/ifid_entry_ram.sv
// Entry storage for if_id_buffer: synchronous write at the tail, asynchronous read at the head.
module ifid_entry_ram #(
   parameter int DEPTH = 2,
   parameter int W     = 32,
   parameter int AW    = 1
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [W-1:0]  wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [W-1:0]  rdata_o
);

   logic [W-1:0] mem_q [DEPTH];

   // NOTE: data storage is deliberately not reset; whether a slot holds a live
   // entry is decided by the occupancy count, so clearing it would only cost logic.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule : ifid_entry_ram

// File: rtl/if_id_buffer.sv
// IF/ID decoupling buffer: circular queue of {instr, pc2} with HALT freeze and flush.
// Optional saturating statistics counters are built when IF_ID_BUFFER_STATS_EN is defined.
module if_id_buffer
   import if_id_buffer_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int IW    = IW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [IW-1:0] in_instr,
   input  logic [IW-1:0] in_pc2,
   output logic          in_ready,
   output logic          out_valid,
   output logic [IW-1:0] out_instr,
   output logic [IW-1:0] out_pc2,
   input  logic          out_ready,
   input  logic          flush,
   output logic          halt_held
`ifdef IF_ID_BUFFER_STATS_EN
   ,
   output logic [15:0]   stat_bubbles,
   output logic [15:0]   stat_full,
   output logic [15:0]   stat_flushes
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [AW-1:0] head_q, head_d;
   logic [AW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic          halt_q, halt_d;

   logic          enq, deq;
   logic [2*IW-1:0] rd_data;

   assign out_valid = (count_q != '0);
   // Full blocks enqueue outright, independent of out_ready, so in_ready stays off the decode stall path.
   assign in_ready  = rst & ~flush & ~halt_q & (count_q < FULL_CNT);
   assign enq       = in_valid & in_ready;
   assign deq       = out_valid & out_ready;
   assign halt_held = halt_q;

   assign out_instr = out_valid ? rd_data[2*IW-1:IW] : IW'(NOP_INSTR);
   assign out_pc2   = out_valid ? rd_data[IW-1:0]    : '0;

   ifid_entry_ram #(
      .DEPTH (DEPTH),
      .W     (2 * IW),
      .AW    (AW)
   ) u_ram (
      .clk     (clk),
      .we_i    (enq),
      .waddr_i (tail_q),
      .wdata_i ({in_instr, in_pc2}),
      .raddr_i (head_q),
      .rdata_o (rd_data)
   );

   // NOTE: every next-state variable gets its hold value first, so no path leaves it unassigned (no latches).
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      halt_d  = halt_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
         halt_d  = 1'b0;
      end else begin
         if (enq) begin
            tail_d = tail_q + 1'b1;
            if (in_instr == IW'(HALT_INSTR)) begin
               halt_d = 1'b1;
            end
         end
         if (deq) begin
            head_d = head_q + 1'b1;
         end
         unique case ({enq, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         halt_q  <= 1'b0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         halt_q  <= halt_d;
      end
   end

`ifdef IF_ID_BUFFER_STATS_EN
   logic [15:0] bubbles_q, full_q, flushes_q;

   // Statistics survive flush; only reset clears them.
   always_ff @(posedge clk) begin
      if (!rst) begin
         bubbles_q <= '0;
         full_q    <= '0;
         flushes_q <= '0;
      end else begin
         if (!out_valid && bubbles_q != 16'hFFFF) begin
            bubbles_q <= bubbles_q + 16'd1;
         end
         if (count_q == FULL_CNT && full_q != 16'hFFFF) begin
            full_q <= full_q + 16'd1;
         end
         if (flush && flushes_q != 16'hFFFF) begin
            flushes_q <= flushes_q + 16'd1;
         end
      end
   end

   assign stat_bubbles = bubbles_q;
   assign stat_full    = full_q;
   assign stat_flushes = flushes_q;
`endif

endmodule : if_id_buffer
